// File: rtl/tx_pam_mapper.sv
// Transmit PAM symbol mapper: frames a PCS byte stream into 4-lane signed symbol vectors for the FFE.
// Optional build macro TX_SCRAMBLE_EN: when defined, data bytes are XOR-scrambled with the LFSR before mapping.
module tx_pam_mapper #(
  parameter int          LEVEL = 32,
  parameter logic [32:0] SEED  = 33'd1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       io_tx_enable,
  input  logic       io_in_valid,
  input  logic       io_in_frame,
  input  logic [7:0] io_in_data,
  output logic       io_in_ready,
  output logic       io_out_valid,
  output logic [7:0] io_out_bits_0,
  output logic [7:0] io_out_bits_1,
  output logic [7:0] io_out_bits_2,
  output logic [7:0] io_out_bits_3,
  output logic       io_underrun
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SSD1 = 3'd1;
  localparam logic [2:0] S_SSD2 = 3'd2;
  localparam logic [2:0] S_DATA = 3'd3;
  localparam logic [2:0] S_ESD1 = 3'd4;
  localparam logic [2:0] S_ESD2 = 3'd5;

  localparam logic [7:0] P2 = 8'(2 * LEVEL);
  localparam logic [7:0] P1 = 8'(LEVEL);
  localparam logic [7:0] N1 = 8'(-LEVEL);
  localparam logic [7:0] N2 = 8'(-2 * LEVEL);

  localparam logic [32:0] SEED_EFF = (SEED == 33'd0) ? 33'd1 : SEED;

  localparam logic [31:0] VEC_SSD1 = {P2, P2, P2, P2};
  localparam logic [31:0] VEC_SSD2 = {N2, P2, P2, P2};
  localparam logic [31:0] VEC_ESD1 = {N2, P2, N2, P2};
  localparam logic [31:0] VEC_ESD2 = {P2, N2, P2, N2};

  logic [2:0]  state_q, state_d;
  logic [32:0] lfsr_q, lfsr_d;
  logic [32:0] lfsr_next_s;
  logic        valid_q, valid_d;
  logic [31:0] bits_q, bits_d;
  logic        ready_q, ready_d;
  logic        underrun_q, underrun_d;
  logic        fire_s;
  logic [7:0]  data_s;

  // Eight serial steps of x^33+x^13+1; the newest bit lands in r[0].
  function automatic logic [32:0] lfsr_advance(input logic [32:0] r_in);
    logic [32:0] r;
    logic        nb;
    r = r_in;
    for (int i = 0; i < 8; i++) begin
      nb = r[32] ^ r[12];
      r  = {r[31:0], nb};
    end
    return r;
  endfunction

  // The first generated bit ends up deepest, so sc is the bit-reversed low byte.
  function automatic logic [7:0] sc_of(input logic [7:0] low);
    logic [7:0] sc;
    for (int i = 0; i < 8; i++) begin
      sc[i] = low[7-i];
    end
    return sc;
  endfunction

  // Idle lanes take sc[3:0], which sit at low[7:4] in reversed order.
  function automatic logic [31:0] idle_vector(input logic [3:0] hi);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      v[8*k +: 8] = hi[3-k] ? P2 : N2;
    end
    return v;
  endfunction

  function automatic logic [7:0] level_of(input logic [1:0] code);
    logic [7:0] lv;
    case (code)
      2'b00:   lv = N2;
      2'b01:   lv = N1;
      2'b10:   lv = P1;
      default: lv = P2;
    endcase
    return lv;
  endfunction

  function automatic logic [31:0] map_byte(input logic [7:0] s);
    logic [31:0] v;
    for (int k = 0; k < 4; k++) begin
      v[8*k +: 8] = level_of(s[2*k +: 2]);
    end
    return v;
  endfunction

  assign lfsr_next_s = lfsr_advance(lfsr_q);
  assign fire_s      = io_in_valid & ready_q;

`ifdef TX_SCRAMBLE_EN
  assign data_s = io_in_data ^ sc_of(lfsr_next_s[7:0]);
`else
  assign data_s = io_in_data;
`endif

  // Next-state, next-vector and flag logic; disable overrides every state.
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    valid_d    = 1'b0;
    bits_d     = 32'h0000_0000;
    underrun_d = underrun_q;
    if (!io_tx_enable) begin
      state_d = S_IDLE;
    end else begin
      valid_d = 1'b1;
      lfsr_d  = lfsr_next_s;
      case (state_q)
        S_IDLE: begin
          bits_d = idle_vector(lfsr_next_s[7:4]);
          if (io_in_valid && io_in_frame) begin
            state_d = S_SSD1;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_SSD1: begin
          bits_d  = VEC_SSD1;
          state_d = S_SSD2;
        end
        S_SSD2: begin
          bits_d  = VEC_SSD2;
          state_d = S_DATA;
        end
        S_DATA: begin
          if (fire_s && io_in_frame) begin
            bits_d  = map_byte(data_s);
            state_d = S_DATA;
          end else if (fire_s) begin
            bits_d  = 32'h0000_0000;
            state_d = S_ESD1;
          end else begin
            bits_d     = 32'h0000_0000;
            underrun_d = 1'b1;
            state_d    = S_ESD1;
          end
        end
        S_ESD1: begin
          bits_d  = VEC_ESD1;
          state_d = S_ESD2;
        end
        S_ESD2: begin
          bits_d  = VEC_ESD2;
          state_d = S_IDLE;
        end
        default: begin
          bits_d  = 32'h0000_0000;
          state_d = S_IDLE;
        end
      endcase
    end
    ready_d = (state_d == S_DATA);
  end

  // State, scrambler and registered outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      lfsr_q     <= SEED_EFF;
      valid_q    <= 1'b0;
      bits_q     <= 32'h0000_0000;
      ready_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      valid_q    <= valid_d;
      bits_q     <= bits_d;
      ready_q    <= ready_d;
      underrun_q <= underrun_d;
    end
  end

  assign io_in_ready   = ready_q;
  assign io_out_valid  = valid_q;
  assign io_out_bits_0 = bits_q[7:0];
  assign io_out_bits_1 = bits_q[15:8];
  assign io_out_bits_2 = bits_q[23:16];
  assign io_out_bits_3 = bits_q[31:24];
  assign io_underrun   = underrun_q;

endmodule
